systolic_feeder_2x2: RTL and testbench
======================================

// Module: systolic_feeder_2x2
// PURPOSE
//  Upstream feeder for the 2x2 systolic array. It loads a 2x2 weight tile through the
//  FDi/load chain, then streams buffered activation vectors into the RD row inputs.
//  Row 1 is skewed one cycle behind row 0. When a job finishes it drains zeros and pulses done.
//  Its outputs connect 1:1 to sa_RD_*, sa_FDi_*, sa_load and sa_bd_PE_* of the array.
// PARAMETERS
//  DATA_WIDTH   16  width of every data word
//  FIFO_DEPTH   4   activation-pair FIFO entries (power of 2, >=2)
//  CNT_W        8   width of the vector count cfg_nvec
//  DRAIN_CYCLES 3   zero cycles driven after the last vector to flush the array
// PORTS
//  clk         in   1             rising-edge clock
//  rst         in   1             synchronous reset, active-low
//  start       in   1             job start pulse; sampled only in IDLE
//  cfg_w       in   4*DATA_WIDTH  {w11,w10,w01,w00}, wRC = row R, column C
//  cfg_bd      in   2             column bd_PE values, latched at start
//  cfg_nvec    in   CNT_W         number of activation vectors in the job
//  in_a0       in   DATA_WIDTH    activation for row 0
//  in_a1       in   DATA_WIDTH    activation for row 1
//  in_valid    in   1             activation pair valid
//  in_ready    out  1             FIFO can accept a pair
//  fd_RD_0     out  DATA_WIDTH    drives sa_RD_0
//  fd_RD_1     out  DATA_WIDTH    drives sa_RD_1 (one-cycle skew)
//  fd_FDi_0    out  DATA_WIDTH    drives sa_FDi_0
//  fd_FDi_1    out  DATA_WIDTH    drives sa_FDi_1
//  fd_load     out  1             drives sa_load
//  fd_bd_PE_0  out  1             drives sa_bd_PE_0
//  fd_bd_PE_1  out  1             drives sa_bd_PE_1
//  busy        out  1             high in every state except IDLE
//  done        out  1             one-cycle pulse when DRAIN exits
// BEHAVIOUR
//  - Reset (rst==0 at a clock edge):
//    - state goes to IDLE and the FIFO is flushed.
//    - All registered outputs (fd_*, busy, done) become 0.
//    - in_ready is 0 while rst==0.
//  - Output registers: all fd_* outputs are registered.
//  - FIFO handshake:
//    - in_ready = !full. It does not depend on pop in the same cycle.
//    - A push happens when in_valid && in_ready. The FIFO accepts pushes in any state, so prefill is allowed.
//    - A simultaneous push and pop leaves the occupancy unchanged.
//    - Pointers wrap modulo FIFO_DEPTH.
//    - Pop happens only in STREAM, only when the FIFO is not empty.
//  - FSM states: IDLE, LOAD1, LOAD2, STREAM, DRAIN.
//    - IDLE -> LOAD1 on start. This latches cfg_w, cfg_bd and cfg_nvec; fd_bd_PE_* = cfg_bd from the next cycle.
//    - LOAD1: fd_FDi_0/1 = w10/w11, fd_load=1.
//    - LOAD2: fd_FDi_0/1 = w00/w01, fd_load=1.
//    - LOAD2 -> STREAM. If cfg_nvec==0, LOAD2 -> DRAIN instead.
//    - Outside LOAD1/LOAD2: fd_load=0 and fd_FDi_*=0.
//    - STREAM, each cycle: pop if the FIFO is not empty; fd_RD_0 = a0 of the popped pair, else 0 (bubble).
//      - skew_r <= a1 of the popped pair, or 0 on a bubble; fd_RD_1 = skew_r (row 1 lags by one cycle).
//      - The issued-vector counter increments only on pop.
//      - After the pop of vector cfg_nvec: -> DRAIN.
//    - DRAIN: lasts DRAIN_CYCLES cycles with fd_RD_0=0. fd_RD_1 emits the skewed last a1 first, then 0.
//      On exit: done=1 for one cycle, -> IDLE, busy=0 in the same cycle as done.
//  - Latency: a pair popped at edge t appears on fd_RD_0 after edge t and on fd_RD_1 after edge t+1.
//    The first vector reaches fd_RD_0 two cycles after LOAD2, if the FIFO is prefilled.
//  - Boundary conditions:
//    - start while busy is ignored.
//    - A FIFO underflow in STREAM inserts bubbles; the job does not abort.
//    - FIFO occupancy beyond cfg_nvec stays in the FIFO for the next job.
//    - Reset mid-job returns to IDLE with no done pulse.
// STRUCTURE
//  - Shared package: state encoding constants (IDLE..DRAIN) and the weight-slice index constants for cfg_w.
//  - One sub-module: pair_fifo (2*DATA_WIDTH wide, FIFO_DEPTH deep, full/empty flags, synchronous active-low reset).
//  - FSM, counters and skew register live in the top module.
// TESTING
//  - Reset: hold rst=0 for 3 cycles mid-STREAM -> all fd_*=0, busy=0, in_ready=0;
//    after release, IDLE and in_ready=1 with the FIFO empty.
//  - Weight load: cfg_w={4,3,2,1}, start -> LOAD1 drives FDi=(3,4), load=1; LOAD2 drives FDi=(1,2), load=1; then load=0.
//  - Skew: prefill pairs (5,6),(7,8), nvec=2 -> RD_0 sequence 5,7,0,0,0; RD_1 sequence 0,6,8,0,0; done once after 3 drain cycles.
//  - Underflow: nvec=3, push (1,2), then a 2-cycle gap, then (3,4),(5,6) -> RD_0 = 1,0,0,3,5; the count completes correctly.
//  - Full/backpressure: push 5 pairs with FIFO_DEPTH=4 in IDLE -> in_ready=0 after 4; the fifth pair is accepted when the first pop occurs.
//  - Edge cases:
//    - nvec=0 -> LOAD2 goes straight to DRAIN with no pop, and done pulses.
//    - start asserted in STREAM -> no effect.

Source files
------------

// File: rtl/systolic_feeder_2x2_pkg.sv
// Shared definitions for the 2x2 systolic array feeder: FSM state encoding
// and the word positions of each weight inside the packed cfg_w bus.
package systolic_feeder_2x2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD1  = 3'd1,
        ST_LOAD2  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4
    } fsm_state_e;

    // cfg_w = {w11, w10, w01, w00}; slice k occupies [k*DATA_WIDTH +: DATA_WIDTH]
    localparam int W00_IDX = 0;
    localparam int W01_IDX = 1;
    localparam int W10_IDX = 2;
    localparam int W11_IDX = 3;

endpackage

// File: rtl/systolic_feeder_2x2_pair_fifo.sv
// Show-ahead FIFO of activation pairs; rdata always presents the oldest entry
// so the feeder can pop and forward it in the same cycle.
module systolic_feeder_2x2_pair_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok;
    logic             pop_ok;

    // The extra pointer bit separates the full and empty cases when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Feeder for the 2x2 systolic array: loads a weight tile over two cycles, then
// streams buffered activation pairs with row 1 skewed one cycle, then drains zeros.
module systolic_feeder_2x2
    import systolic_feeder_2x2_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*DATA_WIDTH-1:0] cfg_w,
    input  logic [1:0]              cfg_bd,
    input  logic [CNT_W-1:0]        cfg_nvec,
    input  logic [DATA_WIDTH-1:0]   in_a0,
    input  logic [DATA_WIDTH-1:0]   in_a1,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   fd_RD_0,
    output logic [DATA_WIDTH-1:0]   fd_RD_1,
    output logic [DATA_WIDTH-1:0]   fd_FDi_0,
    output logic [DATA_WIDTH-1:0]   fd_FDi_1,
    output logic                    fd_load,
    output logic                    fd_bd_PE_0,
    output logic                    fd_bd_PE_1,
    output logic                    busy,
    output logic                    done
);

    localparam int PW   = 2 * DATA_WIDTH;
    localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    fsm_state_e            state_q;
    logic [DATA_WIDTH-1:0] w00_q;
    logic [DATA_WIDTH-1:0] w01_q;
    logic [1:0]            bd_q;
    logic [CNT_W-1:0]      nvec_q;
    logic [CNT_W-1:0]      vcnt_q;
    logic [CNT_W-1:0]      vcnt_d;
    logic [DC_W-1:0]       drain_cnt_q;
    logic [DATA_WIDTH-1:0] skew_q;
    logic [DATA_WIDTH-1:0] rd0_q;
    logic [DATA_WIDTH-1:0] rd1_q;
    logic [DATA_WIDTH-1:0] fdi0_q;
    logic [DATA_WIDTH-1:0] fdi1_q;
    logic                  load_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [PW-1:0]         fifo_wdata;
    logic [PW-1:0]         fifo_rdata;
    logic [DATA_WIDTH-1:0] pop_a0;
    logic [DATA_WIDTH-1:0] pop_a1;

    // in_ready is held low during reset so nothing is pushed into a FIFO being flushed.
    assign in_ready   = rst && !fifo_full;
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == ST_STREAM) && !fifo_empty;
    assign fifo_wdata = {in_a1, in_a0};
    assign pop_a0     = fifo_rdata[DATA_WIDTH-1:0];
    assign pop_a1     = fifo_rdata[PW-1:DATA_WIDTH];
    assign vcnt_d     = vcnt_q + CNT_W'(1);

    systolic_feeder_2x2_pair_fifo #(
        .WIDTH (PW),
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            w00_q       <= '0;
            w01_q       <= '0;
            bd_q        <= '0;
            nvec_q      <= '0;
            vcnt_q      <= '0;
            drain_cnt_q <= '0;
            skew_q      <= '0;
            rd0_q       <= '0;
            rd1_q       <= '0;
            fdi0_q      <= '0;
            fdi1_q      <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // Defaults: data buses idle at zero, row 1 always trails the skew stage.
            done_q <= 1'b0;
            load_q <= 1'b0;
            fdi0_q <= '0;
            fdi1_q <= '0;
            rd0_q  <= '0;
            skew_q <= '0;
            rd1_q  <= skew_q;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        w00_q   <= cfg_w[W00_IDX*DATA_WIDTH +: DATA_WIDTH];
                        w01_q   <= cfg_w[W01_IDX*DATA_WIDTH +: DATA_WIDTH];
                        bd_q    <= cfg_bd;
                        nvec_q  <= cfg_nvec;
                        vcnt_q  <= '0;
                        fdi0_q  <= cfg_w[W10_IDX*DATA_WIDTH +: DATA_WIDTH];
                        fdi1_q  <= cfg_w[W11_IDX*DATA_WIDTH +: DATA_WIDTH];
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD1;
                    end
                end
                ST_LOAD1: begin
                    fdi0_q  <= w00_q;
                    fdi1_q  <= w01_q;
                    load_q  <= 1'b1;
                    state_q <= ST_LOAD2;
                end
                ST_LOAD2: begin
                    drain_cnt_q <= '0;
                    state_q     <= (nvec_q == '0) ? ST_DRAIN : ST_STREAM;
                end
                ST_STREAM: begin
                    // An empty FIFO leaves the zero defaults in place as a bubble.
                    if (pop) begin
                        rd0_q  <= pop_a0;
                        skew_q <= pop_a1;
                        vcnt_q <= vcnt_d;
                        if (vcnt_d == nvec_q) begin
                            drain_cnt_q <= '0;
                            state_q     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fd_RD_0    = rd0_q;
    assign fd_RD_1    = rd1_q;
    assign fd_FDi_0   = fdi0_q;
    assign fd_FDi_1   = fdi1_q;
    assign fd_load    = load_q;
    assign fd_bd_PE_0 = bd_q[0];
    assign fd_bd_PE_1 = bd_q[1];
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2: weight load, skewed streaming,
// underflow bubbles, backpressure, leftover entries and reset behaviour.
module tb_systolic_feeder_2x2;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [4*DW-1:0] cfg_w;
    logic [1:0]    cfg_bd;
    logic [7:0]    cfg_nvec;
    logic [DW-1:0] in_a0;
    logic [DW-1:0] in_a1;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] fd_RD_0;
    logic [DW-1:0] fd_RD_1;
    logic [DW-1:0] fd_FDi_0;
    logic [DW-1:0] fd_FDi_1;
    logic          fd_load;
    logic          fd_bd_PE_0;
    logic          fd_bd_PE_1;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_feeder_2x2 #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (4),
        .CNT_W        (8),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_w      (cfg_w),
        .cfg_bd     (cfg_bd),
        .cfg_nvec   (cfg_nvec),
        .in_a0      (in_a0),
        .in_a1      (in_a1),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fd_RD_0    (fd_RD_0),
        .fd_RD_1    (fd_RD_1),
        .fd_FDi_0   (fd_FDi_0),
        .fd_FDi_1   (fd_FDi_1),
        .fd_load    (fd_load),
        .fd_bd_PE_0 (fd_bd_PE_0),
        .fd_bd_PE_1 (fd_bd_PE_1),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; outputs then reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] nvec);
        cfg_nvec = nvec;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_initial();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_a0 = '0; in_a1 = '0;
        cfg_w = '0; cfg_bd = '0; cfg_nvec = '0;
        tick(); tick();
        n_checks++;
        if ({fd_RD_0, fd_RD_1, fd_FDi_0, fd_FDi_1, fd_load, fd_bd_PE_0, fd_bd_PE_1, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got RD0=%0d RD1=%0d FDi0=%0d FDi1=%0d load=%b busy=%b done=%b, want all 0",
                     fd_RD_0, fd_RD_1, fd_FDi_0, fd_FDi_1, fd_load, busy, done);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
        $display("reset_initial: in_ready=%b busy=%b", in_ready, busy);
    endtask

    // Weight load with nvec=0, which also goes straight from LOAD2 to DRAIN.
    task automatic test_weight_load();
        cfg_w  = {16'd4, 16'd3, 16'd2, 16'd1};
        cfg_bd = 2'b10;
        cfg_nvec = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_w = '0;
        cfg_bd = 2'b00;
        n_checks++;
        if (fd_FDi_0 !== 16'd3 || fd_FDi_1 !== 16'd4 || fd_load !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load1: got FDi=(%0d,%0d) load=%b busy=%b want (3,4) 1 1", fd_FDi_0, fd_FDi_1, fd_load, busy);
        end
        n_checks++;
        if ({fd_bd_PE_1, fd_bd_PE_0} !== 2'b10) begin
            n_fail++;
            $display("FAIL bd_latch: got %b%b want 10", fd_bd_PE_1, fd_bd_PE_0);
        end
        tick();
        n_checks++;
        if (fd_FDi_0 !== 16'd1 || fd_FDi_1 !== 16'd2 || fd_load !== 1'b1) begin
            n_fail++;
            $display("FAIL load2: got FDi=(%0d,%0d) load=%b want (1,2) 1", fd_FDi_0, fd_FDi_1, fd_load);
        end
        tick();
        n_checks++;
        if (fd_FDi_0 !== 16'd0 || fd_FDi_1 !== 16'd0 || fd_load !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_end: got FDi=(%0d,%0d) load=%b busy=%b want (0,0) 0 1", fd_FDi_0, fd_FDi_1, fd_load, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            $display("nvec0 drain cycle %0d: done=%b busy=%b RD0=%0d", i, done, busy, fd_RD_0);
            n_checks++;
            if (done !== (i == 2) || busy !== (i < 2) || fd_RD_0 !== 16'd0) begin
                n_fail++;
                $display("FAIL nvec0_drain[%0d]: got done=%b busy=%b RD0=%0d want done=%b busy=%b RD0=0",
                         i, done, busy, fd_RD_0, (i == 2), (i < 2));
            end
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nvec0_no_pop: got in_ready=%b want 1", in_ready);
        end
    endtask

    // Prefilled skew test; start is also held high during STREAM and must be ignored.
    task automatic test_skew();
        int exp0 [5];
        int exp1 [5];
        exp0 = '{5, 7, 0, 0, 0};
        exp1 = '{0, 6, 8, 0, 0};
        in_valid = 1'b1; in_a0 = 16'd5; in_a1 = 16'd6;
        tick();
        in_a0 = 16'd7; in_a1 = 16'd8;
        tick();
        in_valid = 1'b0;
        start_job(8'd2);
        n_checks++;
        if (fd_RD_0 !== 16'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL skew_stream_entry: got RD0=%0d busy=%b want 0 1", fd_RD_0, busy);
        end
        for (int i = 0; i < 5; i++) begin
            start = (i < 2);
            tick();
            $display("skew cycle %0d: RD0=%0d RD1=%0d done=%b", i, fd_RD_0, fd_RD_1, done);
            n_checks++;
            if (fd_RD_0 !== 16'(exp0[i]) || fd_RD_1 !== 16'(exp1[i]) || done !== (i == 4)) begin
                n_fail++;
                $display("FAIL skew[%0d]: got RD0=%0d RD1=%0d done=%b want %0d %0d %b",
                         i, fd_RD_0, fd_RD_1, done, exp0[i], exp1[i], (i == 4));
            end
        end
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || fd_load !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored: got busy=%b done=%b load=%b want 0 0 0", busy, done, fd_load);
        end
    endtask

    task automatic test_underflow();
        int exp0 [8];
        int exp1 [8];
        exp0 = '{1, 0, 0, 3, 5, 0, 0, 0};
        exp1 = '{0, 2, 0, 0, 4, 6, 0, 0};
        cfg_nvec = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_a0 = 16'd1; in_a1 = 16'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i == 2) || (i == 3);
            in_a0 = (i == 2) ? 16'd3 : 16'd5;
            in_a1 = (i == 2) ? 16'd4 : 16'd6;
            tick();
            $display("underflow cycle %0d: RD0=%0d RD1=%0d done=%b", i, fd_RD_0, fd_RD_1, done);
            n_checks++;
            if (fd_RD_0 !== 16'(exp0[i]) || fd_RD_1 !== 16'(exp1[i]) || done !== (i == 7)) begin
                n_fail++;
                $display("FAIL underflow[%0d]: got RD0=%0d RD1=%0d done=%b want %0d %0d %b",
                         i, fd_RD_0, fd_RD_1, done, exp0[i], exp1[i], (i == 7));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a0 = 16'(11 + 2 * i); in_a1 = 16'(12 + 2 * i);
            tick();
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_after_4: got in_ready=%b want 0", in_ready);
        end
        in_a0 = 16'd19; in_a1 = 16'd20;
        start_job(8'd1);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_before_pop: got in_ready=%b want 0", in_ready);
        end
        tick();
        $display("backpressure pop: RD0=%0d in_ready=%b", fd_RD_0, in_ready);
        n_checks++;
        if (fd_RD_0 !== 16'd11 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pop: got RD0=%0d in_ready=%b want 11 1", fd_RD_0, in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fifth_accepted: got in_ready=%b want 0", in_ready);
        end
        in_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: got done=%b want 1", done);
        end
    endtask

    // Entries left by the previous job must feed the next job in order.
    task automatic test_leftover();
        start_job(8'd2);
        tick();
        n_checks++;
        if (fd_RD_0 !== 16'd13) begin
            n_fail++;
            $display("FAIL leftover0: got RD0=%0d want 13", fd_RD_0);
        end
        tick();
        n_checks++;
        if (fd_RD_0 !== 16'd15) begin
            n_fail++;
            $display("FAIL leftover1: got RD0=%0d want 15", fd_RD_0);
        end
        tick(); tick(); tick();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL leftover_done: got done=%b want 1", done);
        end
        $display("leftover job: done=%b", done);
    endtask

    task automatic test_reset_mid_job();
        start_job(8'd4);
        tick();
        n_checks++;
        if (fd_RD_0 !== 16'd17) begin
            n_fail++;
            $display("FAIL midjob_pop: got RD0=%0d want 17", fd_RD_0);
        end
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if ({fd_RD_0, fd_RD_1, fd_FDi_0, fd_FDi_1, fd_load, fd_bd_PE_0, fd_bd_PE_1, busy, done} !== '0
            || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midjob_reset: got RD0=%0d RD1=%0d load=%b busy=%b done=%b in_ready=%b want all 0",
                     fd_RD_0, fd_RD_1, fd_load, busy, done, in_ready);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL after_release[%0d]: got done=%b busy=%b in_ready=%b want 0 0 1", i, done, busy, in_ready);
            end
        end
        start_job(8'd1);
        tick();
        n_checks++;
        if (fd_RD_0 !== 16'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flushed_bubble: got RD0=%0d busy=%b want 0 1", fd_RD_0, busy);
        end
        in_valid = 1'b1; in_a0 = 16'd21; in_a1 = 16'd22;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (fd_RD_0 !== 16'd21) begin
            n_fail++;
            $display("FAIL post_flush_pop: got RD0=%0d want 21", fd_RD_0);
        end
        tick(); tick(); tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_flush_done: got done=%b busy=%b want 1 0", done, busy);
        end
        $display("reset_mid_job: recovered job done=%b", done);
    endtask

    initial begin
        test_reset_initial();
        test_weight_load();
        test_skew();
        test_underflow();
        test_backpressure();
        test_leftover();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
